// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Reads opcode (and optional immediate) bytes from program memory over a
// req/ack handshake and presents assembled instructions to the decoder over
// valid/ready. Fetch stops permanently once a halt (opcode 0) is accepted.
// Optional feature: define FETCH_TRACE_EN to print each accepted instruction
// in simulation; with it undefined no trace logic is compiled.
module fetch_unit #(
    parameter int unsigned       w          = 8,
    parameter int unsigned       op_w       = 3,
    parameter int unsigned       addr_w     = 8,
    parameter logic [addr_w-1:0] reset_addr = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    output logic                mem_req,
    output logic [addr_w-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [w-1:0]        mem_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [op_w-1:0]     op,
    output logic [w-op_w-1:0]   arg,
    output logic [w-1:0]        imm,
    output logic [addr_w-1:0]   inst_pc,
    output logic                halted
);

    typedef enum logic [1:0] {
        S_FETCH_OP  = 2'd0,
        S_FETCH_IMM = 2'd1,
        S_ISSUE     = 2'd2,
        S_HALTED    = 2'd3
    } state_t;

    // set, addv and subv carry an immediate byte
    function automatic logic two_byte(input logic [op_w-1:0] o);
        return (o == op_w'(2)) || (o == op_w'(5)) || (o == op_w'(7));
    endfunction

    state_t              state_q, state_d;
    logic [addr_w-1:0]   pc_q, pc_d;
    logic                req_q, req_d;
    logic [addr_w-1:0]   addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [op_w-1:0]     op_q, op_d;
    logic [w-op_w-1:0]   arg_q, arg_d;
    logic [w-1:0]        imm_q, imm_d;
    logic [addr_w-1:0]   ipc_q, ipc_d;
    logic                halted_q, halted_d;

    logic [addr_w-1:0]   pc_inc;
    logic [op_w-1:0]     fetched_op;
    logic                mem_done;

    assign pc_inc     = pc_q + addr_w'(1);   // wraps modulo 2^addr_w
    assign fetched_op = mem_data[w-1:w-op_w];
    assign mem_done   = req_q && mem_ack;    // ack only counts while requesting

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        op_d     = op_q;
        arg_d    = arg_q;
        imm_d    = imm_q;
        ipc_d    = ipc_q;
        halted_d = halted_q;
        unique case (state_q)
            S_FETCH_OP: begin
                if (mem_done) begin
                    op_d  = fetched_op;
                    arg_d = mem_data[w-op_w-1:0];
                    ipc_d = pc_q;
                    pc_d  = pc_inc;
                    if (two_byte(fetched_op)) begin
                        // keep requesting; address moves to the immediate byte
                        state_d = S_FETCH_IMM;
                        req_d   = 1'b1;
                        addr_d  = pc_inc;
                    end else begin
                        state_d = S_ISSUE;
                        imm_d   = '0;
                        req_d   = 1'b0;
                        valid_d = 1'b1;
                    end
                end else begin
                    // covers the first cycle after reset, when req is still low
                    req_d  = 1'b1;
                    addr_d = pc_q;
                end
            end
            S_FETCH_IMM: begin
                if (mem_done) begin
                    imm_d   = mem_data;
                    pc_d    = pc_inc;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (valid_q && inst_ready) begin
                    valid_d = 1'b0;
                    if (op_q == '0) begin
                        state_d  = S_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        state_d = S_FETCH_OP;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
            end
            S_HALTED: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: state_d = S_HALTED;
        endcase
    end

    // State and output registers; reset abandons any in-flight read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_FETCH_OP;
            pc_q     <= reset_addr;
            req_q    <= 1'b0;
            addr_q   <= reset_addr;
            valid_q  <= 1'b0;
            op_q     <= '0;
            arg_q    <= '0;
            imm_q    <= '0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            op_q     <= op_d;
            arg_q    <= arg_d;
            imm_q    <= imm_d;
            ipc_q    <= ipc_d;
            halted_q <= halted_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign inst_valid = valid_q;
    assign op         = op_q;
    assign arg        = arg_q;
    assign imm        = imm_q;
    assign inst_pc    = ipc_q;
    assign halted     = halted_q;

`ifdef FETCH_TRACE_EN
    // Simulation trace of every accepted instruction.
    always @(posedge clock) begin
        if (reset_n && valid_q && inst_ready)
            $display("fetch %h: op=%0d arg=%h imm=%h", ipc_q, op_q, arg_q, imm_q);
    end
`endif

endmodule
